rtc_calendar_bank: RTL and testbench

Parametrised time/date register bank for the clock–calendar datapath. It holds seconds, minutes, hours, day, month and year as binary counters. In run mode a 1 Hz tick ripples a carry chain through all six fields. In edit mode one field is adjusted with Up/Dw and wraps without carry. Day-of-month is limited by month length and leap year, and every field leaves the block as registered 8-bit BCD with a selectable 12/24 h hour format.

---
 rtl/rtc_calendar_bank_if.sv | 40 ++++
 rtl/rtc_calendar_bank.sv | 193 +++++++++++++++++++
 tb/tb_rtc_calendar_bank.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_calendar_bank_if.sv
// rtc_calendar_bank_if
//   Groups the control inputs and BCD display outputs of rtc_calendar_bank.
//   master : the side that drives Tick/Edit_en/Field_sel/Up/Dw/Format
//            and reads the display fields.
//   slave  : the calendar bank itself.
//   Signals:
//     Tick       1 Hz one-cycle pulse (run mode)
//     Edit_en    1 = edit mode
//     Field_sel  0 sec, 1 min, 2 hr, 3 day, 4 month, 5 year, 6/7 none
//     Up, Dw     one-cycle adjust requests (edit mode)
//     Format     0 = 24 h, 1 = 12 h hour display
//     Seg..As    BCD sec, min, hr, day, month, year
//     Pm         internal hour >= 12
//     Year_wrap  one-cycle pulse on run-mode year 99 -> 00
interface rtc_calendar_bank_if;
  logic       Tick;
  logic       Edit_en;
  logic [2:0] Field_sel;
  logic       Up;
  logic       Dw;
  logic       Format;
  logic [7:0] Seg;
  logic [7:0] Min;
  logic [7:0] Hr;
  logic [7:0] Ds;
  logic [7:0] Ms;
  logic [7:0] As;
  logic       Pm;
  logic       Year_wrap;

  modport master (
    output Tick, Edit_en, Field_sel, Up, Dw, Format,
    input  Seg, Min, Hr, Ds, Ms, As, Pm, Year_wrap
  );

  modport slave (
    input  Tick, Edit_en, Field_sel, Up, Dw, Format,
    output Seg, Min, Hr, Ds, Ms, As, Pm, Year_wrap
  );
endinterface

// File: rtl/rtc_calendar_bank.sv
// rtc_calendar_bank
//   Time/date register bank. Binary counters for sec, min, hr, day, month
//   and year advance on a 1 Hz Tick through a single-edge carry chain
//   (run mode) or are adjusted one field at a time with Up/Dw wrapping
//   without carry (edit mode). Every field is presented as registered
//   BCD one edge after the binary registers change.
//   Ports:
//     Clock_in  system clock, rising edge
//     Reset_in  synchronous active-high reset, loads INIT_* values and
//               drives the outputs straight to their BCD init values
//     bus       rtc_calendar_bank_if.slave (controls and BCD outputs)
//   Optional feature macro: LEAP_YEAR_EN -- when defined, February has
//   29 days in years with year[1:0]==0; otherwise February is 28 days.
module rtc_calendar_bank #(
  parameter int INIT_YEAR  = 16,
  parameter int INIT_MONTH = 1,
  parameter int INIT_DAY   = 1,
  parameter int INIT_HOUR  = 0
) (
  input  logic                 Clock_in,
  input  logic                 Reset_in,
  rtc_calendar_bank_if.slave   bus
);

  localparam logic [6:0] INIT_YEAR_B  = 7'(INIT_YEAR);
  localparam logic [3:0] INIT_MONTH_B = 4'(INIT_MONTH);
  localparam logic [4:0] INIT_DAY_B   = 5'(INIT_DAY);
  localparam logic [4:0] INIT_HOUR_B  = 5'(INIT_HOUR);

  function automatic logic [4:0] max_day(input logic [3:0] m, input logic leap);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: max_day = 5'd30;
      4'd2:                    max_day = leap ? 5'd29 : 5'd28;
      default:                 max_day = 5'd31;
    endcase
  endfunction

  // Binary 0..99 to packed BCD by repeated subtraction of ten.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [6:0] rem;
    tens = 4'd0;
    rem  = v;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    to_bcd = {tens, 4'(rem)};
  endfunction

  // 24 h internal hour to the displayed hour value.
  function automatic logic [4:0] hr_disp(input logic [4:0] h, input logic fmt12);
    if (!fmt12)          hr_disp = h;
    else if (h == 5'd0)  hr_disp = 5'd12;
    else if (h > 5'd12)  hr_disp = h - 5'd12;
    else                 hr_disp = h;
  endfunction

  logic [5:0] sec_p0, sec_n;
  logic [5:0] min_p0, min_n;
  logic [4:0] hr_p0, hr_n;
  logic [4:0] day_p0, day_n;
  logic [3:0] month_p0, month_n;
  logic [6:0] year_p0, year_n;
  logic       wrap_p0, wrap_n;
  logic       leap_c, leap_n;
  logic [4:0] md_c, md_n;

  logic [7:0] seg_p1, min_p1, hr_p1, day_p1, month_p1, year_p1;
  logic       pm_p1, year_wrap_p1;

  always_comb begin
    sec_n   = sec_p0;
    min_n   = min_p0;
    hr_n    = hr_p0;
    day_n   = day_p0;
    month_n = month_p0;
    year_n  = year_p0;
    wrap_n  = 1'b0;
`ifdef LEAP_YEAR_EN
    leap_c = (year_p0[1:0] == 2'd0);
`else
    leap_c = 1'b0;
`endif
    md_c = max_day(month_p0, leap_c);

    if (!bus.Edit_en) begin
      if (bus.Tick) begin
        // Full carry chain resolves within this single edge.
        if (sec_p0 != 6'd59) sec_n = sec_p0 + 6'd1;
        else begin
          sec_n = 6'd0;
          if (min_p0 != 6'd59) min_n = min_p0 + 6'd1;
          else begin
            min_n = 6'd0;
            if (hr_p0 != 5'd23) hr_n = hr_p0 + 5'd1;
            else begin
              hr_n = 5'd0;
              if (day_p0 < md_c) day_n = day_p0 + 5'd1;
              else begin
                day_n = 5'd1;
                if (month_p0 != 4'd12) month_n = month_p0 + 4'd1;
                else begin
                  month_n = 4'd1;
                  if (year_p0 != 7'd99) year_n = year_p0 + 7'd1;
                  else begin
                    year_n = 7'd0;
                    wrap_n = 1'b1;
                  end
                end
              end
            end
          end
        end
      end
    end else if (bus.Up != bus.Dw) begin
      case (bus.Field_sel)
        3'd0: sec_n = bus.Up ? ((sec_p0 == 6'd59) ? 6'd0 : sec_p0 + 6'd1)
                             : ((sec_p0 == 6'd0) ? 6'd59 : sec_p0 - 6'd1);
        3'd1: min_n = bus.Up ? ((min_p0 == 6'd59) ? 6'd0 : min_p0 + 6'd1)
                             : ((min_p0 == 6'd0) ? 6'd59 : min_p0 - 6'd1);
        3'd2: hr_n = bus.Up ? ((hr_p0 == 5'd23) ? 5'd0 : hr_p0 + 5'd1)
                            : ((hr_p0 == 5'd0) ? 5'd23 : hr_p0 - 5'd1);
        3'd3: day_n = bus.Up ? ((day_p0 >= md_c) ? 5'd1 : day_p0 + 5'd1)
                             : ((day_p0 <= 5'd1) ? md_c : day_p0 - 5'd1);
        3'd4: month_n = bus.Up ? ((month_p0 == 4'd12) ? 4'd1 : month_p0 + 4'd1)
                               : ((month_p0 == 4'd1) ? 4'd12 : month_p0 - 4'd1);
        3'd5: year_n = bus.Up ? ((year_p0 == 7'd99) ? 7'd0 : year_p0 + 7'd1)
                              : ((year_p0 == 7'd0) ? 7'd99 : year_p0 - 7'd1);
        default: ;
      endcase
    end

    // Month/year edits can leave the day beyond the new month length.
`ifdef LEAP_YEAR_EN
    leap_n = (year_n[1:0] == 2'd0);
`else
    leap_n = 1'b0;
`endif
    md_n = max_day(month_n, leap_n);
    if (bus.Edit_en && (day_n > md_n)) day_n = md_n;
  end

  always_ff @(posedge Clock_in) begin
    if (Reset_in) begin
      sec_p0       <= 6'd0;
      min_p0       <= 6'd0;
      hr_p0        <= INIT_HOUR_B;
      day_p0       <= INIT_DAY_B;
      month_p0     <= INIT_MONTH_B;
      year_p0      <= INIT_YEAR_B;
      wrap_p0      <= 1'b0;
      seg_p1       <= 8'h00;
      min_p1       <= 8'h00;
      hr_p1        <= to_bcd({2'b00, hr_disp(INIT_HOUR_B, bus.Format)});
      day_p1       <= to_bcd({2'b00, INIT_DAY_B});
      month_p1     <= to_bcd({3'b000, INIT_MONTH_B});
      year_p1      <= to_bcd(INIT_YEAR_B);
      pm_p1        <= (INIT_HOUR_B >= 5'd12);
      year_wrap_p1 <= 1'b0;
    end else begin
      // p0: binary field registers
      sec_p0       <= sec_n;
      min_p0       <= min_n;
      hr_p0        <= hr_n;
      day_p0       <= day_n;
      month_p0     <= month_n;
      year_p0      <= year_n;
      wrap_p0      <= wrap_n;
      // p1: registered BCD display
      seg_p1       <= to_bcd({1'b0, sec_p0});
      min_p1       <= to_bcd({1'b0, min_p0});
      hr_p1        <= to_bcd({2'b00, hr_disp(hr_p0, bus.Format)});
      day_p1       <= to_bcd({2'b00, day_p0});
      month_p1     <= to_bcd({3'b000, month_p0});
      year_p1      <= to_bcd(year_p0);
      pm_p1        <= (hr_p0 >= 5'd12);
      year_wrap_p1 <= wrap_p0;
    end
  end

  assign bus.Seg       = seg_p1;
  assign bus.Min       = min_p1;
  assign bus.Hr        = hr_p1;
  assign bus.Ds        = day_p1;
  assign bus.Ms        = month_p1;
  assign bus.As        = year_p1;
  assign bus.Pm        = pm_p1;
  assign bus.Year_wrap = year_wrap_p1;

endmodule

// File: tb/tb_rtc_calendar_bank.sv
// tb_rtc_calendar_bank
//   Self-checking bench for rtc_calendar_bank. A calendar model held as
//   plain integers is advanced with normalising arithmetic; every cycle
//   all eight outputs are compared against the model state from the
//   previous edge. Directed sequences cover reset, year rollover,
//   February clamping, 12 h display and edit-mode freezing, followed by
//   randomized stimulus.
module tb_rtc_calendar_bank;

  localparam int INIT_YEAR  = 16;
  localparam int INIT_MONTH = 1;
  localparam int INIT_DAY   = 1;
  localparam int INIT_HOUR  = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rtc_calendar_bank_if bus();

  rtc_calendar_bank #(
    .INIT_YEAR (INIT_YEAR),
    .INIT_MONTH(INIT_MONTH),
    .INIT_DAY  (INIT_DAY),
    .INIT_HOUR (INIT_HOUR)
  ) dut (
    .Clock_in(clk),
    .Reset_in(rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  int m_sec, m_min, m_hr, m_day, m_month, m_year;
  bit m_wrap;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int days_in(input int m, input int y);
    case (m)
      2: begin
`ifdef LEAP_YEAR_EN
        days_in = (y % 4 == 0) ? 29 : 28;
`else
        days_in = 28 + 0 * y;
`endif
      end
      4, 6, 9, 11: days_in = 30;
      default:     days_in = 31;
    endcase
  endfunction

  function automatic logic [7:0] bcd(input int v);
    bcd = 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic int hdisp(input int h, input bit f12);
    if (!f12)        hdisp = h;
    else if (h == 0) hdisp = 12;
    else if (h > 12) hdisp = h - 12;
    else             hdisp = h;
  endfunction

  function automatic int step_wrap(input int v, input int lo, input int hi, input bit up);
    int n;
    n = hi - lo + 1;
    step_wrap = lo + ((v - lo + (up ? 1 : n - 1)) % n);
  endfunction

  task automatic model_reset();
    m_sec = 0; m_min = 0; m_hr = INIT_HOUR;
    m_day = INIT_DAY; m_month = INIT_MONTH; m_year = INIT_YEAR;
    m_wrap = 1'b0;
  endtask

  task automatic model_tick();
    m_sec++;
    if (m_sec == 60) begin m_sec = 0; m_min++; end
    if (m_min == 60) begin m_min = 0; m_hr++; end
    if (m_hr == 24) begin m_hr = 0; m_day++; end
    if (m_day > days_in(m_month, m_year)) begin m_day = 1; m_month++; end
    if (m_month == 13) begin m_month = 1; m_year++; end
    if (m_year == 100) begin m_year = 0; m_wrap = 1'b1; end
  endtask

  task automatic model_edit(input int sel, input bit up);
    case (sel)
      0: m_sec   = step_wrap(m_sec, 0, 59, up);
      1: m_min   = step_wrap(m_min, 0, 59, up);
      2: m_hr    = step_wrap(m_hr, 0, 23, up);
      3: m_day   = step_wrap(m_day, 1, days_in(m_month, m_year), up);
      4: m_month = step_wrap(m_month, 1, 12, up);
      5: m_year  = step_wrap(m_year, 0, 99, up);
      default: ;
    endcase
    if (m_day > days_in(m_month, m_year)) m_day = days_in(m_month, m_year);
  endtask

  // One clock: drive inputs, check outputs after the edge, advance model.
  task automatic do_cycle(input bit r, input bit t, input bit e, input int sel,
                          input bit u, input bit d, input bit f);
    int es, emi, eh, ed, emo, ey;
    bit ew;
    rst = r;
    bus.Tick = t; bus.Edit_en = e; bus.Field_sel = 3'(sel);
    bus.Up = u; bus.Dw = d; bus.Format = f;
    @(posedge clk);
    #1;
    if (r) begin
      es = 0; emi = 0; eh = INIT_HOUR; ed = INIT_DAY; emo = INIT_MONTH; ey = INIT_YEAR; ew = 1'b0;
    end else begin
      es = m_sec; emi = m_min; eh = m_hr; ed = m_day; emo = m_month; ey = m_year; ew = m_wrap;
    end
    check_val("seg", bus.Seg, bcd(es));
    check_val("min", bus.Min, bcd(emi));
    check_val("hr", bus.Hr, bcd(hdisp(eh, f)));
    check_val("day", bus.Ds, bcd(ed));
    check_val("month", bus.Ms, bcd(emo));
    check_val("year", bus.As, bcd(ey));
    check_val("pm", bus.Pm, (eh >= 12) ? 1 : 0);
    check_val("year_wrap", bus.Year_wrap, ew ? 1 : 0);
    if (r) model_reset();
    else begin
      m_wrap = 1'b0;
      if (!e) begin
        if (t) model_tick();
      end else if (u != d) model_edit(sel, u);
    end
  endtask

  task automatic idle(input bit f);
    do_cycle(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, f);
  endtask

  task automatic edit(input int sel, input bit u, input bit d);
    do_cycle(1'b0, 1'b0, 1'b1, sel, u, d, 1'b0);
  endtask

  task automatic do_reset();
    do_cycle(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  int hr_tgt[5]  = '{0, 11, 12, 13, 23};
  int hr_exp[5]  = '{8'h12, 8'h11, 8'h12, 8'h01, 8'h11};
  int pm_exp[5]  = '{0, 0, 1, 1, 1};

  initial begin
    int cur;
    model_reset();

    // Reset state
    do_reset();
    idle(1'b0);
    check_val("rst_seg", bus.Seg, 8'h00);
    check_val("rst_min", bus.Min, 8'h00);
    check_val("rst_hr", bus.Hr, 8'h00);
    check_val("rst_ds", bus.Ds, 8'h01);
    check_val("rst_ms", bus.Ms, 8'h01);
    check_val("rst_as", bus.As, 8'h16);
    check_val("rst_pm", bus.Pm, 0);
    check_val("rst_yw", bus.Year_wrap, 0);

    // Seconds down-wrap, then Up=Dw=1 and unselected fields
    edit(0, 1'b0, 1'b1);
    idle(1'b0);
    check_val("sec_dw_wrap", bus.Seg, 8'h59);
    check_val("sec_dw_min", bus.Min, 8'h00);
    edit(0, 1'b1, 1'b1);
    edit(6, 1'b1, 1'b0);
    edit(7, 1'b0, 1'b1);
    idle(1'b0);
    check_val("sec_updw", bus.Seg, 8'h59);

    // Build 99-12-31 23:59:59 and roll over
    do_reset();
    edit(0, 1'b0, 1'b1);
    edit(1, 1'b0, 1'b1);
    edit(2, 1'b0, 1'b1);
    edit(4, 1'b0, 1'b1);
    edit(3, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) edit(5, 1'b0, 1'b1);
    do_cycle(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check_val("roll_hms", {bus.Hr, bus.Min, bus.Seg}, 24'h000000);
    check_val("roll_date", {bus.As, bus.Ms, bus.Ds}, 24'h000101);
    check_val("yw_high", bus.Year_wrap, 1);
    idle(1'b0);
    check_val("yw_low", bus.Year_wrap, 0);

    // 31 Jan -> Feb clamp in year 16, then year 17
    do_reset();
    edit(3, 1'b0, 1'b1);
    edit(4, 1'b1, 1'b0);
    idle(1'b0);
    check_val("feb16_ms", bus.Ms, 8'h02);
`ifdef LEAP_YEAR_EN
    check_val("feb16_ds", bus.Ds, 8'h29);
`else
    check_val("feb16_ds", bus.Ds, 8'h28);
`endif
    do_reset();
    edit(5, 1'b1, 1'b0);
    edit(3, 1'b0, 1'b1);
    edit(4, 1'b1, 1'b0);
    idle(1'b0);
    check_val("feb17_ds", bus.Ds, 8'h28);

    // 12 h display sweep
    do_reset();
    cur = 0;
    for (int i = 0; i < 5; i++) begin
      while (cur < hr_tgt[i]) begin
        edit(2, 1'b1, 1'b0);
        cur++;
      end
      idle(1'b1);
      idle(1'b1);
      check_val("hr12", bus.Hr, 32'(hr_exp[i]));
      check_val("pm12", bus.Pm, 32'(pm_exp[i]));
    end

    // Ticks dropped in edit mode; reset beats Up on the same edge
    do_reset();
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b1, 1'b1, 7, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check_val("frozen_seg", bus.Seg, 8'h00);
    edit(1, 1'b1, 1'b0);
    do_cycle(1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0);
    check_val("rst_up_min", bus.Min, 8'h00);
    idle(1'b0);
    check_val("rst_up_min2", bus.Min, 8'h00);

    // Randomized stimulus
    for (int i = 0; i < 3000; i++) begin
      bit r, t, e, u, d, f;
      int sel;
      r   = ($urandom_range(0, 199) == 0);
      e   = ($urandom_range(0, 2) == 0);
      t   = ($urandom_range(0, 1) == 1);
      u   = ($urandom_range(0, 1) == 1);
      d   = ($urandom_range(0, 2) == 0);
      f   = ($urandom_range(0, 1) == 1);
      sel = int'($urandom_range(0, 7));
      do_cycle(r, t, e, sel, u, d, f);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
